ball_ctl: RTL and testbench

Frame-rate game controller for the PONG video pipeline. Once per frame, at the rising edge of vertical blanking, it advances ball position, resolves wall and paddle collisions against the paddle position `ypos`, and sequences serve, play, miss and game-over phases. Its `ball_x`, `ball_y`, `score` and `lives` outputs feed the draw stages alongside the paddle rectangle.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/frame_tick.sv | 30 +++
 rtl/ball_ctl.sv | 217 +++++++++++++++++++++
 tb/tb_ball_ctl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared PONG definitions: controller phases, screen/paddle geometry defaults
// and the ball centre position.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        MISS,
        OVER
    } state_t;

    localparam int DEF_H_RES     = 800;
    localparam int DEF_V_RES     = 600;
    localparam int DEF_BALL_SIZE = 16;
    localparam int DEF_PADDLE_X  = 20;
    localparam int DEF_PADDLE_W  = 16;
    localparam int DEF_PADDLE_H  = 100;

    function automatic int centre(input int res, input int size);
        return res / 2 - size / 2;
    endfunction

    localparam int CX = centre(DEF_H_RES, DEF_BALL_SIZE);
    localparam int CY = centre(DEF_V_RES, DEF_BALL_SIZE);

endpackage

// File: rtl/frame_tick.sv
// Registered rising-edge detector: one-cycle pulse after level goes 0->1.
module frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        prev_d  = level;
        pulse_d = level & ~prev_q;
    end

    // prev resets high so a level already high at release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/ball_ctl.sv
// PONG ball/game controller, advanced once per frame on the vblank rising edge.
// Optional feature macro: BALL_SPEEDUP_EN (speed +1 on every 4th paddle hit).
module ball_ctl
    import pong_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int PADDLE_X    = DEF_PADDLE_X,
    parameter int PADDLE_W    = DEF_PADDLE_W,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int STEP        = 4,
    parameter int MAX_SPEED   = 8,
    parameter int SERVE_DELAY = 60,
    parameter int LIVES       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [11:0] ypos,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over
);

    localparam int              SPW        = $clog2(MAX_SPEED + 1);
    localparam logic [12:0]     X_MAX      = 13'(H_RES - BALL_SIZE);
    localparam logic [12:0]     Y_MAX      = 13'(V_RES - BALL_SIZE);
    localparam logic [12:0]     X_CTR      = 13'(centre(H_RES, BALL_SIZE));
    localparam logic [12:0]     Y_CTR      = 13'(centre(V_RES, BALL_SIZE));
    localparam logic [12:0]     PAD_R      = 13'(PADDLE_X + PADDLE_W);
    localparam logic [12:0]     BSZ        = 13'(BALL_SIZE);
    localparam logic [12:0]     PAD_H      = 13'(PADDLE_H);
    localparam logic [SPW-1:0]  SPD_INIT   = SPW'(STEP);
    localparam logic [15:0]     SERVE_LAST = 16'(SERVE_DELAY - 1);
    localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
`ifdef BALL_SPEEDUP_EN
    localparam logic [SPW-1:0]  SPD_MAX    = SPW'(MAX_SPEED);
`endif

    state_t         state_q, state_d;
    logic [12:0]    x_q, x_d, y_q, y_d;
    logic           right_q, right_d, down_q, down_d;
    logic [SPW-1:0] speed_q, speed_d;
    logic [7:0]     score_q, score_d;
    logic [1:0]     lives_q, lives_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           over_q, over_d;

    logic           tick, start_edge;
    logic [12:0]    spd, ypos_w;
    logic           overlap;
    logic [7:0]     score_inc;

    frame_tick u_vblnk_tick (
        .clk   (clk),
        .rst_n (rst),
        .level (vblnk_in),
        .pulse (tick)
    );

    frame_tick u_start_edge (
        .clk   (clk),
        .rst_n (rst),
        .level (start),
        .pulse (start_edge)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        right_d   = right_q;
        down_d    = down_q;
        speed_d   = speed_q;
        score_d   = score_q;
        lives_d   = lives_q;
        cnt_d     = '0;
        spd       = 13'(speed_q);
        ypos_w    = {1'b0, ypos};
        overlap   = (y_q + BSZ > ypos_w) && (y_q < ypos_w + PAD_H);
        score_inc = (score_q == '1) ? score_q : score_q + 8'd1;

        case (state_q)
            IDLE: begin
                x_d     = X_CTR;
                y_d     = Y_CTR;
                right_d = 1'b1;
                down_d  = 1'b1;
                speed_d = SPD_INIT;
                if (start_edge) begin
                    state_d = SERVE;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            SERVE: begin
                x_d     = X_CTR;
                y_d     = Y_CTR;
                right_d = 1'b1;
                down_d  = 1'b1;
                speed_d = SPD_INIT;
                cnt_d   = cnt_q;
                if (tick) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (down_q) begin
                        if (y_q + spd > Y_MAX) begin
                            y_d    = Y_MAX;
                            down_d = 1'b0;
                        end else begin
                            y_d = y_q + spd;
                        end
                    end else if (y_q < spd) begin
                        y_d    = '0;
                        down_d = 1'b1;
                    end else begin
                        y_d = y_q - spd;
                    end

                    // x - s < PAD_R rewritten as x < PAD_R + s to avoid underflow
                    if (right_q) begin
                        if (x_q + spd > X_MAX) begin
                            x_d     = X_MAX;
                            right_d = 1'b0;
                        end else begin
                            x_d = x_q + spd;
                        end
                    end else if (x_q >= PAD_R && x_q < PAD_R + spd && overlap) begin
                        x_d     = PAD_R;
                        right_d = 1'b1;
                        score_d = score_inc;
`ifdef BALL_SPEEDUP_EN
                        if (score_inc[1:0] == 2'b00 && speed_q < SPD_MAX)
                            speed_d = speed_q + 1'b1;
`endif
                    end else if (x_q < spd) begin
                        state_d = MISS;
                    end else begin
                        x_d = x_q - spd;
                    end
                end
            end
            MISS: begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d = OVER;
                end else begin
                    state_d = SERVE;
                    x_d     = X_CTR;
                    y_d     = Y_CTR;
                    right_d = 1'b1;
                    down_d  = 1'b1;
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d = IDLE;
                    x_d     = X_CTR;
                    y_d     = Y_CTR;
                    right_d = 1'b1;
                    down_d  = 1'b1;
                    speed_d = SPD_INIT;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: state_d = IDLE;
        endcase

        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            right_q <= 1'b1;
            down_q  <= 1'b1;
            speed_q <= SPD_INIT;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            cnt_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            right_q <= right_d;
            down_q  <= down_d;
            speed_q <= speed_d;
            score_q <= score_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
        end
    end

    assign ball_x    = x_q[11:0];
    assign ball_y    = y_q[11:0];
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: frame-level game model plus literal checkpoints.
module tb_ball_ctl;

    localparam int H_RES = 800, V_RES = 600, BS = 16;
    localparam int PAD_R = 36, PAD_H = 100, STEP = 4, MAX_SPEED = 8;
    localparam int CXM = H_RES / 2 - BS / 2, CYM = V_RES / 2 - BS / 2;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;
    localparam int Y_TRACK = 0, Y_AVOID = 1;

    logic        clk = 1'b0;
    logic        rst, vblnk_in, start;
    logic [11:0] ypos;
    logic [11:0] ball_x, ball_y;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        game_over;

    int vectors = 0, miscompares = 0;

    int m_phase, mx, my, ms, mscore, mlives, mserve, ptick, ymode;
    bit mright, mdown, chk_en = 1'b0;

    always #5 clk = ~clk;

    ball_ctl dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk_in  (vblnk_in),
        .start     (start),
        .ypos      (ypos),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score     (score),
        .lives     (lives),
        .game_over (game_over)
    );

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (ball_x !== 12'(mx) || ball_y !== 12'(my) || score !== 8'(mscore) ||
                lives !== 2'(mlives) || game_over !== (m_phase == M_OVER)) begin
                miscompares++;
                $display("FAIL model t=%0t: x=%0d y=%0d score=%0d lives=%0d over=%0d, expected %0d %0d %0d %0d %0d",
                         $time, ball_x, ball_y, score, lives, game_over,
                         mx, my, mscore, mlives, m_phase == M_OVER);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task model_centre();
        mx = CXM; my = CYM; mright = 1'b1; mdown = 1'b1; ms = STEP;
    endtask

    task model_reset();
        m_phase = M_IDLE; mscore = 0; mlives = 3; ptick = 0;
        model_centre();
    endtask

    task model_tick();
        int yp;
        bit ov;
        yp = int'(ypos);
        if (m_phase == M_SERVE) begin
            mserve--;
            if (mserve == 0) begin
                m_phase = M_PLAY;
                ptick = 0;
            end
        end else if (m_phase == M_PLAY) begin
            ptick++;
            ov = (my + BS > yp) && (my < yp + PAD_H);
            if (mdown) begin
                if (my + ms > V_RES - BS) begin my = V_RES - BS; mdown = 1'b0; end
                else my += ms;
            end else begin
                if (my < ms) begin my = 0; mdown = 1'b1; end
                else my -= ms;
            end
            if (mright) begin
                if (mx + ms > H_RES - BS) begin mx = H_RES - BS; mright = 1'b0; end
                else mx += ms;
            end else if (mx >= PAD_R && mx - ms < PAD_R && ov) begin
                mx = PAD_R; mright = 1'b1;
                if (mscore < 255) mscore++;
`ifdef BALL_SPEEDUP_EN
                if (mscore % 4 == 0 && ms < MAX_SPEED) ms++;
`endif
            end else if (mx < ms) begin
                mlives--;
                if (mlives == 0) m_phase = M_OVER;
                else begin
                    m_phase = M_SERVE; mserve = 60;
                    model_centre();
                end
            end else begin
                mx -= ms;
            end
        end
    endtask

    // One frame: vblank high for 3 clocks (update + MISS resolution), then 4 checked clocks.
    task frame();
        if (ymode == Y_TRACK) ypos = 12'((my >= 40) ? my - 40 : 0);
        else                  ypos = 12'((my < 300) ? my + 200 : my - 200);
        vblnk_in = 1'b1;
        model_tick();
        step(3);
        vblnk_in = 1'b0;
        chk_en = 1'b1;
        step(4);
        chk_en = 1'b0;
    endtask

    task press_start();
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(3);
        if (m_phase == M_IDLE) begin
            m_phase = M_SERVE; mserve = 60; mscore = 0; mlives = 3;
        end else if (m_phase == M_OVER) begin
            model_reset();
        end
    endtask

    initial begin
        int guard, prev_lives;
        rst = 1'b0; vblnk_in = 1'b0; start = 1'b0; ypos = '0; ymode = Y_TRACK;
        model_reset();
        step(3);
        check("reset_x", ball_x, 392);
        check("reset_y", ball_y, 292);
        check("reset_score", score, 0);
        check("reset_lives", lives, 3);
        check("reset_over", game_over, 0);
        rst = 1'b1;

        repeat (5) frame();
        check("idle_x", ball_x, 392);
        check("idle_y", ball_y, 292);

        press_start();
        repeat (60) frame();
        check("serve_x", ball_x, 392);
        check("serve_y", ball_y, 292);
        frame();
        check("play1_x", ball_x, 396);
        check("play1_y", ball_y, 296);

        guard = 0;
        while (ptick < 288 && guard < 400) begin
            frame();
            guard++;
            if (ptick == 10) press_start();
            if (ptick == 73)  check("wall_t73_y", ball_y, 584);
            if (ptick == 74)  check("wall_t74_y", ball_y, 584);
            if (ptick == 75)  check("wall_t75_y", ball_y, 580);
            if (ptick == 99)  check("rwall_x", ball_x, 784);
            if (ptick == 287) begin
                check("hit_x", ball_x, 36);
                check("hit_score", score, 1);
            end
            if (ptick == 288) check("hit_dir_x", ball_x, 40);
        end
        check("hit_reached", ptick, 288);

        while (ptick < 300) frame();
        ymode = Y_AVOID;
        guard = 0;
        while (m_phase != M_OVER && guard < 3000) begin
            prev_lives = mlives;
            frame();
            guard++;
            if (prev_lives == 3 && mlives == 2) begin
                check("miss1_lives", lives, 2);
                check("miss1_x", ball_x, 392);
                check("miss1_y", ball_y, 292);
            end
        end
        check("over_reached", m_phase, M_OVER);
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);

        press_start();
        check("restart_lives", lives, 3);
        check("restart_score", score, 0);
        check("restart_over", game_over, 0);
        check("restart_x", ball_x, 392);

        press_start();
        ymode = Y_TRACK;
        repeat (65) frame();
        check("pre_rst_x", ball_x, 412);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_x", ball_x, 392);
        check("async_rst_y", ball_y, 292);
        check("async_rst_score", score, 0);
        check("async_rst_lives", lives, 3);
        check("async_rst_over", game_over, 0);
        model_reset();
        step(1);
        rst = 1'b1;
        repeat (3) frame();
        check("post_rst_idle_x", ball_x, 392);
        press_start();
        repeat (60) frame();
        check("reserve_x", ball_x, 392);
        frame();
        check("replay_x", ball_x, 396);
        check("replay_y", ball_y, 296);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
